// File: rtl/riscv_pkg.sv
// Shared core types: bus access sizes and the data-memory controller states.
package riscv_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HWORD = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } biu_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/riscv_dmem_sram.sv
// Single-port data SRAM: synchronous read with one cycle of latency, byte-masked write.
module riscv_dmem_sram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [3:0]               be,
  input  logic                     we,
  input  logic [XLEN-1:0]          d,
  output logic [XLEN-1:0]          q
);

  logic [XLEN-1:0] mem [DEPTH];

  // Read-during-write returns the old word; the controller never uses it.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= d[8*i +: 8];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory responder: request decode, fault flags, request latch and access sequencing.
//   state  | meaning
//   IDLE   | waiting for dmem_req; latches the request on acceptance
//   WAIT   | burning the programmed wait states
//   ACCESS | SRAM read or byte-masked write is issued at this edge
//   RESP   | dmem_ack high for one cycle with the read data
module riscv_dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned    XLEN        = 32,
  parameter int unsigned    DEPTH       = 1024,
  parameter logic [XLEN-1:0] BASE       = '0,
  parameter int unsigned    WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic [XLEN-1:0] dmem_d,
  input  logic            dmem_we,
  input  biu_size_t       dmem_size,
  output logic            dmem_ack,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  dmem_state_t     state;
  logic [3:0]      wcnt;
  logic [AW-1:0]   adr_l;
  logic [XLEN-1:0] d_l;
  logic            we_l;
  logic [3:0]      be_l;
  logic            fault_l;
  logic            q_en;
  logic            mis_raw;
  logic            oor;
  logic [3:0]      be_raw;
  logic            sram_we;
  logic [XLEN-1:0] sram_q;

  always_comb begin
    mis_raw = 1'b0;
    be_raw  = 4'b0000;
    unique case (dmem_size)
      BYTE:  be_raw = 4'b0001 << dmem_adr[1:0];
      HWORD: begin
        mis_raw = dmem_adr[0];
        be_raw  = 4'b0011 << dmem_adr[1:0];
      end
      WORD: begin
        mis_raw = |dmem_adr[1:0];
        be_raw  = 4'b1111;
      end
      default: mis_raw = 1'b1;
    endcase
  end

  // BASE is aligned to the array size, so range check reduces to the upper address bits.
  assign oor             = dmem_adr[XLEN-1:AW+2] != BASE[XLEN-1:AW+2];
  assign dmem_misaligned = dmem_req & mis_raw;
  assign dmem_page_fault = dmem_req & ~mis_raw & oor;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      wcnt    <= 4'd0;
      adr_l   <= '0;
      d_l     <= '0;
      we_l    <= 1'b0;
      be_l    <= 4'b0000;
      fault_l <= 1'b0;
      dmem_ack <= 1'b0;
      q_en    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dmem_req) begin
            adr_l   <= dmem_adr[AW+1:2];
            d_l     <= dmem_d;
            we_l    <= dmem_we;
            be_l    <= be_raw;
            fault_l <= mis_raw | oor;
            if (WS != 4'd0) begin
              wcnt  <= WS - 4'd1;
              state <= WAIT;
            end else begin
              state <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (wcnt == 4'd0) state <= ACCESS;
          else              wcnt  <= wcnt - 4'd1;
        end
        ACCESS: begin
          dmem_ack <= 1'b1;
          q_en     <= ~we_l & ~fault_l;
          state    <= RESP;
        end
        RESP: begin
          dmem_ack <= 1'b0;
          q_en     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sram_we = (state == ACCESS) & we_l & ~fault_l;
  assign dmem_q  = q_en ? sram_q : '0;

  riscv_dmem_sram #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_sram (
    .clk  (clk),
    .addr (adr_l),
    .be   (be_l),
    .we   (sram_we),
    .d    (d_l),
    .q    (sram_q)
  );

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Self-checking bench: two controller instances (0 and 3 wait states) against a word-array reference model.
module tb_riscv_dmem_ctrl;
  import riscv_pkg::*;

  localparam logic [31:0] BASE_T = 32'h0;
  localparam int          NBYTES = 4096;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_s  [2];
  logic [31:0] adr_s  [2];
  logic [31:0] d_s    [2];
  logic        we_s   [2];
  biu_size_t   size_s [2];
  logic        ack_s  [2];
  logic [31:0] q_s    [2];
  logic        mis_s  [2];
  logic        pf_s   [2];

  int checks = 0;
  int failures = 0;
  int ws_of [2] = '{0, 3};

  logic [31:0] mm [2][1024];
  bit          kn [2][1024];

  always #5 clk = ~clk;

  riscv_dmem_ctrl #(.XLEN(32), .DEPTH(1024), .BASE(BASE_T), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .dmem_req(req_s[0]), .dmem_adr(adr_s[0]), .dmem_d(d_s[0]),
    .dmem_we(we_s[0]), .dmem_size(size_s[0]), .dmem_ack(ack_s[0]), .dmem_q(q_s[0]),
    .dmem_misaligned(mis_s[0]), .dmem_page_fault(pf_s[0]));

  riscv_dmem_ctrl #(.XLEN(32), .DEPTH(1024), .BASE(BASE_T), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .dmem_req(req_s[1]), .dmem_adr(adr_s[1]), .dmem_d(d_s[1]),
    .dmem_we(we_s[1]), .dmem_size(size_s[1]), .dmem_ack(ack_s[1]), .dmem_q(q_s[1]),
    .dmem_misaligned(mis_s[1]), .dmem_page_fault(pf_s[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One complete request with flag, latency, data and single-cycle-ack checks.
  task automatic txn(input int k, input logic [31:0] adr, input logic [31:0] d,
                     input logic we, input biu_size_t size, input string tag);
    bit mis, oor, pf, known;
    int n, wi, off, nb;
    logic [31:0] expq, w;
    mis = (size == HWORD && adr % 2 != 0) || (size == WORD && adr % 4 != 0) || size == DWORD;
    oor = (adr < BASE_T) || (adr - BASE_T >= NBYTES);
    pf  = !mis && oor;
    wi  = int'(((adr - BASE_T) >> 2) & 32'd1023);
    @(negedge clk);
    adr_s[k] = adr; d_s[k] = d; we_s[k] = we; size_s[k] = size; req_s[k] = 1'b1;
    #1;
    chk({tag, "_mis"}, {31'd0, mis_s[k]}, {31'd0, mis});
    chk({tag, "_pf"},  {31'd0, pf_s[k]},  {31'd0, pf});
    n = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
    end while (!ack_s[k] && n < 40);
    chk({tag, "_ack"}, {31'd0, ack_s[k]}, 32'd1);
    chk({tag, "_lat"}, n, 2 + ws_of[k]);
    known = 1'b1;
    if (mis || pf || we) expq = 32'd0;
    else begin
      expq  = mm[k][wi];
      known = kn[k][wi];
    end
    if (known) chk({tag, "_q"}, q_s[k], expq);
    req_s[k] = 1'b0;
    if (we && !mis && !pf) begin
      off = int'(adr % 4);
      nb  = (size == BYTE) ? 1 : (size == HWORD) ? 2 : 4;
      w   = mm[k][wi];
      for (int b = 0; b < 4; b++)
        if (b >= off && b < off + nb) w[8*b +: 8] = d[8*b +: 8];
      if (nb == 4 || kn[k][wi]) kn[k][wi] = 1'b1;
      mm[k][wi] = w;
    end
    @(negedge clk);
    chk({tag, "_ack1"}, {31'd0, ack_s[k]}, 32'd0);
  endtask

  initial begin
    int acks [$];
    int r, n;
    bit prev;
    logic [31:0] a;
    for (int k = 0; k < 2; k++) begin
      req_s[k] = 1'b0; adr_s[k] = '0; d_s[k] = '0; we_s[k] = 1'b0; size_s[k] = WORD;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ack", {31'd0, ack_s[k]}, 32'd0);
      chk("rst_q", q_s[k], 32'd0);
      chk("rst_flags", {30'd0, mis_s[k], pf_s[k]}, 32'd0);
    end
    @(negedge clk); rstn = 1'b1;

    txn(0, 32'h10, 32'hDEADBEEF, 1'b1, WORD, "wr10");
    txn(0, 32'h10, 32'h0, 1'b0, WORD, "rd10");
    txn(0, 32'h20, 32'h11223344, 1'b1, WORD, "pre20");
    txn(0, 32'h22, 32'h00AA0000, 1'b1, BYTE, "wrb22");
    txn(0, 32'h22, 32'hBBCC0000, 1'b1, HWORD, "wrh22");
    txn(0, 32'h20, 32'h0, 1'b0, WORD, "rd20");
    chk("lane_word", mm[0][8], 32'hBBCC3344);
    txn(0, 32'h21, 32'h0, 1'b0, WORD, "mis21");
    txn(0, 32'h20, 32'h0, 1'b0, WORD, "rd20b");
    txn(0, 32'h0, 32'h0BADF00D, 1'b1, WORD, "wr0");
    txn(0, 32'h1000, 32'hFFFFFFFF, 1'b1, WORD, "oor");
    txn(0, 32'h0, 32'h0, 1'b0, WORD, "rd0");

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) txn(k, 32'(i * 4), $urandom, 1'b1, WORD, "prew");
      for (int i = 0; i < 30; i++) begin
        r = $urandom_range(0, 9);
        if (r < 8)       a = 32'($urandom_range(0, 63));
        else if (r == 8) a = 32'h1000 + 32'($urandom_range(0, 255));
        else             a = 32'hFFFF_FFFC;
        txn(k, a, $urandom, 1'($urandom_range(0, 1)), biu_size_t'($urandom_range(0, 3)), "rnd");
      end
    end

    // Back-to-back reads with req held on the 3-wait-state instance.
    txn(1, 32'h40, 32'h5A5AA5A5, 1'b1, WORD, "wr40");
    @(negedge clk);
    adr_s[1] = 32'h40; we_s[1] = 1'b0; size_s[1] = WORD; req_s[1] = 1'b1;
    prev = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); @(negedge clk);
      if (ack_s[1]) begin
        acks.push_back(e);
        chk("b2b_q", q_s[1], 32'h5A5AA5A5);
        chk("b2b_dbl", {31'd0, prev}, 32'd0);
      end
      prev = ack_s[1];
    end
    req_s[1] = 1'b0;
    chk("b2b_cnt", acks.size(), 2);
    if (acks.size() == 2) begin
      chk("b2b_first", acks[0], 4);
      chk("b2b_second", acks[1], 10);
    end

    // Reset while in WAIT, then again while the ack is being presented.
    @(negedge clk); @(negedge clk);
    adr_s[1] = 32'h40; we_s[1] = 1'b0; size_s[1] = WORD; req_s[1] = 1'b1;
    @(posedge clk); @(negedge clk); @(posedge clk); #2;
    rstn = 1'b0; #1;
    chk("rstw_ack", {31'd0, ack_s[1]}, 32'd0);
    chk("rstw_q", q_s[1], 32'd0);
    req_s[1] = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    req_s[1] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
    end while (!ack_s[1] && n < 40);
    chk("rstr_pre_q", q_s[1], 32'h5A5AA5A5);
    rstn = 1'b0; #1;
    chk("rstr_ack", {31'd0, ack_s[1]}, 32'd0);
    chk("rstr_q", q_s[1], 32'd0);
    req_s[1] = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    txn(1, 32'h40, 32'h0, 1'b0, WORD, "post_rst");
    txn(1, 32'h0, 32'h0, 1'b0, WORD, "post_rst0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_ctrl.md
# riscv_dmem_ctrl

Data-memory responder for the core's data-side memory interface. It accepts one request at a time from the execution stage's load-store unit and flags misaligned and out-of-range accesses combinationally. Valid requests access a tightly coupled, byte-enabled SRAM, with a programmable number of wait states. It sits between the EX-stage data port and on-chip data RAM; there is no cache or MMU in the path.

## Interface
- XLEN, 32: data/address width; only 32 is supported.
- DEPTH, 1024: SRAM size in XLEN-bit words; power of two.
- BASE, 'h0000_0000: byte address of word 0; must be aligned to DEPTH*4.
- WAIT_STATES, 0: extra cycles inserted before each acknowledge; range 0..15.

- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- dmem_req  in  1  access request; held with all request fields until dmem_ack.
- dmem_adr  in  XLEN  byte address.
- dmem_d  in  XLEN  write data, already lane-positioned by the initiator.
- dmem_we  in  1  1 = write, 0 = read.
- dmem_size  in  biu_size_t  access size: BYTE, HWORD or WORD. DWORD is treated as misaligned.
- dmem_ack  out  1  one-cycle acknowledge; completes the request.
- dmem_q  out  XLEN  read data, full unshifted word, valid only while dmem_ack=1.
- dmem_misaligned  out  1  combinational; high while the held request is misaligned.
- dmem_page_fault  out  1  combinational; high while the held request's address is outside [BASE, BASE+DEPTH*4).

## Operation
- Misaligned condition, decoded from dmem_adr and dmem_size:
  - HWORD with adr[0]=1;
  - WORD with adr[1:0]≠0;
  - any DWORD request.
- Byte enables for aligned requests:
  - BYTE: 4'b0001 << adr[1:0];
  - HWORD: 4'b0011 << adr[1:0];
  - WORD: 4'b1111.
- Faulting request (misaligned or out of range):
  - it is acknowledged on the normal schedule, so the initiator never hangs;
  - no SRAM write occurs and dmem_q=0.
  - misaligned has priority: page_fault is masked while misaligned=1.
- Fault flags are qualified by dmem_req; both are 0 when dmem_req=0.
- FSM states:
  - IDLE: on dmem_req=1, latch adr/d/we/byte-enables/fault. Go to WAIT if WAIT_STATES>0, else ACCESS.
  - WAIT: decrement the wait counter; at 0 go to ACCESS.
  - ACCESS: issue the SRAM read or the byte-masked write. Go to RESP.
  - RESP: dmem_ack=1, dmem_q = registered SRAM output (0 on fault or write). Go to IDLE.
- Only one request is outstanding. Requests are accepted in IDLE only. A dmem_req still high during RESP is not sampled; it is re-evaluated in the following IDLE cycle.
- Writes update the SRAM at the ACCESS clock edge. A read issued after the write's ack returns the new data.
- Reset mid-operation:
  - the FSM returns to IDLE and dmem_ack/dmem_q clear asynchronously;
  - the SRAM contents are retained; a write in ACCESS at the same edge as reset assertion is not guaranteed.

## Timing
- Reset values: dmem_ack=0, dmem_q=0, state=IDLE, wait counter=0. dmem_misaligned and dmem_page_fault are combinational from inputs.
- Request accepted at edge N (IDLE, req=1). ACCESS occupies cycle N+1+WAIT_STATES. dmem_ack is high in cycle N+2+WAIT_STATES.
- Throughput is one access per 3+WAIT_STATES cycles when the initiator keeps req high.
- The initiator may deassert dmem_req in the cycle after dmem_ack, or present the next request then.
- Changing the request fields between acceptance and ack is an initiator error. The latched values are used regardless.
- The SRAM has synchronous read with 1-cycle latency; no combinational path from inputs to dmem_q.

## Structure
- biu_size_t already lives in riscv_pkg. Add dmem_state_t (IDLE, WAIT, ACCESS, RESP) to riscv_pkg.
- Sub-module riscv_dmem_sram (DEPTH, XLEN):
  - single port: clk, addr, be[3:0], we, d, q;
  - synchronous read and byte-masked write; no reset on the array.
- riscv_dmem_ctrl holds the decode, fault logic, request latch, FSM and wait counter.

## Test plan
- WAIT_STATES=0, BASE=0:
  - WORD write 'hDEADBEEF to 'h10; ack in cycle N+2.
  - WORD read 'h10 returns q='hDEADBEEF with ack; both faults 0.
- Byte lanes:
  - preload 'h11223344 at 'h20;
  - BYTE write d='h00AA0000 to 'h22, then HWORD write d='hBBCC0000 to 'h22;
  - WORD read returns 'hBBCC3344.
- Misaligned:
  - WORD read at 'h21: misaligned=1 while req is high, page_fault=0;
  - ack arrives on schedule with q=0;
  - the following read of 'h20 shows the memory unchanged.
- Out of range with DEPTH=1024:
  - WORD write to 'h1000: page_fault=1, ack with no write;
  - a read of 'h0 is unaffected.
- WAIT_STATES=3, back-to-back reads with req held:
  - ack at N+5, next ack at N+11;
  - ack is never high for two consecutive cycles.
- Assert rstn low during WAIT:
  - dmem_ack=0 and dmem_q=0 immediately;
  - after release, a new read completes normally with the earlier SRAM data intact.
